// File: rtl/pad_scheduler.sv
// Frame-synchronous drum pad controller: shadowed pad positions committed on vsync rise,
// per-pad hit flash, fixed-priority pixel arbitration. Flash logic built only with PAD_SCHED_FLASH_EN.
module pad_scheduler #(
  parameter int          NUM_PADS     = 4,
  parameter int          WIDTH        = 64,
  parameter int          HEIGHT       = 64,
  parameter logic [23:0] BASE_COLOR   = 24'h00_80_FF,
  parameter logic [23:0] FLASH_COLOR  = 24'hFF_FF_FF,
  parameter int          FLASH_FRAMES = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [10:0]         hcount,
  input  logic [9:0]          vcount,
  input  logic                vsync,
  input  logic [NUM_PADS-1:0] hit,
  input  logic                upd_valid,
  output logic                upd_ready,
  input  logic [2:0]          upd_id,
  input  logic [10:0]         upd_x,
  input  logic [9:0]          upd_y,
  output logic [23:0]         pixel,
  output logic [NUM_PADS-1:0] flash_active,
  output logic                frame_start
);

  logic                vsync_q;
  logic                commit;
  logic [10:0]         shadow_x [NUM_PADS];
  logic [9:0]          shadow_y [NUM_PADS];
  logic [10:0]         act_x    [NUM_PADS];
  logic [9:0]          act_y    [NUM_PADS];
  logic [NUM_PADS-1:0] in_pad;
  logic [23:0]         pix_next;

  assign commit    = vsync & ~vsync_q;
  assign upd_ready = ~commit;

  // vsync_q resets high so a vsync already high at reset release is not a commit
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vsync_q     <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      vsync_q     <= vsync;
      frame_start <= commit;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_PADS; i++) begin
        shadow_x[i] <= 11'(64 + 256 * i);
        shadow_y[i] <= 10'd600;
        act_x[i]    <= 11'(64 + 256 * i);
        act_y[i]    <= 10'd600;
      end
    end else begin
      // ids beyond NUM_PADS match no slot and are silently dropped
      if (upd_valid && upd_ready) begin
        for (int i = 0; i < NUM_PADS; i++) begin
          if (upd_id == 3'(i)) begin
            shadow_x[i] <= upd_x;
            shadow_y[i] <= upd_y;
          end
        end
      end
      if (commit) begin
        for (int i = 0; i < NUM_PADS; i++) begin
          act_x[i] <= shadow_x[i];
          act_y[i] <= shadow_y[i];
        end
      end
    end
  end

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_hit
    logic [11:0] x_end;
    logic [10:0] y_end;
    assign x_end = {1'b0, act_x[g]} + 12'(WIDTH);
    assign y_end = {1'b0, act_y[g]} + 11'(HEIGHT);
    assign in_pad[g] = (hcount >= act_x[g]) && ({1'b0, hcount} < x_end) &&
                       (vcount >= act_y[g]) && ({1'b0, vcount} < y_end);
  end

  // scan from highest index down so the lowest covering pad is written last
  always_comb begin
    pix_next = '0;
    for (int i = NUM_PADS - 1; i >= 0; i--) begin
      if (in_pad[i]) pix_next = flash_active[i] ? FLASH_COLOR : BASE_COLOR;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pixel <= '0;
    else        pixel <= pix_next;
  end

`ifdef PAD_SCHED_FLASH_EN
  // state | meaning
  // IDLE  | cnt == 0, pad drawn in BASE_COLOR
  // FLASH | cnt > 0, counts down one per commit, pad drawn in FLASH_COLOR
  typedef enum logic {IDLE, FLASH} flash_state_t;

  for (genvar g = 0; g < NUM_PADS; g++) begin : g_flash
    flash_state_t state;
    logic [7:0]   cnt;
    logic         active_q;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state    <= IDLE;
        cnt      <= '0;
        active_q <= 1'b0;
      end else if (hit[g]) begin
        state    <= FLASH;
        cnt      <= 8'(FLASH_FRAMES);
        active_q <= 1'b1;
      end else if (commit && state == FLASH) begin
        cnt <= cnt - 8'd1;
        if (cnt == 8'd1) begin
          state    <= IDLE;
          active_q <= 1'b0;
        end
      end
    end

    assign flash_active[g] = active_q;
  end
`else
  logic unused_flash;
  assign unused_flash = ^{hit, 8'(FLASH_FRAMES)};
  assign flash_active = '0;
`endif

endmodule

// File: tb/tb_pad_scheduler.sv
// Directed self-checking bench for pad_scheduler; flash expectations follow PAD_SCHED_FLASH_EN.
module tb_pad_scheduler;

`ifdef PAD_SCHED_FLASH_EN
  localparam bit FE = 1'b1;
`else
  localparam bit FE = 1'b0;
`endif
  localparam logic [23:0] BASE  = 24'h0080FF;
  localparam logic [23:0] FLASH = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] hcount;
  logic [9:0]  vcount;
  logic        vsync;
  logic [3:0]  hit;
  logic        upd_valid;
  logic        upd_ready;
  logic [2:0]  upd_id;
  logic [10:0] upd_x;
  logic [9:0]  upd_y;
  logic [23:0] pixel;
  logic [3:0]  flash_active;
  logic        frame_start;

  int tests  = 0;
  int failed = 0;

  pad_scheduler dut (
    .clk(clk), .rst_n(rst_n), .hcount(hcount), .vcount(vcount), .vsync(vsync),
    .hit(hit), .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_id(upd_id),
    .upd_x(upd_x), .upd_y(upd_y), .pixel(pixel), .flash_active(flash_active),
    .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [23:0] obs, input logic [23:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic upd(input logic [2:0] id, input logic [10:0] x, input logic [9:0] y);
    upd_valid = 1'b1;
    upd_id    = id;
    upd_x     = x;
    upd_y     = y;
  endtask

  task automatic probe(input logic [10:0] x, input logic [9:0] y);
    hcount = x;
    vcount = y;
  endtask

  // vsync low one cycle, then high; returns just after the commit edge
  task automatic rise(input logic [3:0] h);
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    hit   = h;
    tick();
    hit   = '0;
  endtask

  initial begin
    rst_n = 1'b0; vsync = 1'b1; hit = '0;
    upd_valid = 1'b0; upd_id = '0; upd_x = '0; upd_y = '0;
    probe(11'd64, 10'd600);
    repeat (3) @(posedge clk);
    #1;
    check("rst_pixel", pixel, 24'h0);
    check("rst_flash", {20'h0, flash_active}, 24'h0);
    check("rst_frame_start", {23'h0, frame_start}, 24'h0);
    check("rst_ready", {23'h0, upd_ready}, 24'h1);

    rst_n = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("vsync_high_no_frame", {23'h0, frame_start}, 24'h0);
    end
    check("pad0_default", pixel, BASE);

    // pad 1 to (500,100), visible only after the next commit
    vsync = 1'b0;
    tick();
    tick();
    upd(3'd1, 11'd500, 10'd100);
    check("ready_idle", {23'h0, upd_ready}, 24'h1);
    tick();
    upd_valid = 1'b0;
    probe(11'd510, 10'd110);
    tick();
    check("pre_commit", pixel, 24'h0);
    vsync = 1'b1;
    #1;
    check("ready_in_c", {23'h0, upd_ready}, 24'h0);
    tick();
    check("frame_start_c1", {23'h0, frame_start}, 24'h1);
    check("pixel_from_c", pixel, 24'h0);
    tick();
    check("frame_start_c2", {23'h0, frame_start}, 24'h0);
    check("post_commit", pixel, BASE);

    // update offered only during C is dropped
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    upd(3'd3, 11'd900, 10'd300);
    #1;
    check("ready_c_upd", {23'h0, upd_ready}, 24'h0);
    tick();
    upd_valid = 1'b0;
    rise('0);
    probe(11'd910, 10'd310);
    tick();
    check("c_update_dropped", pixel, 24'h0);

    // same update held into C+1 is accepted
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    upd(3'd3, 11'd900, 10'd300);
    tick();
    check("ready_c_plus1", {23'h0, upd_ready}, 24'h1);
    tick();
    upd_valid = 1'b0;
    check("held_in_shadow", pixel, 24'h0);
    rise('0);
    tick();
    check("held_committed", pixel, BASE);

    // pads 0 and 1 overlapped at (300,300)
    vsync = 1'b0;
    upd(3'd0, 11'd300, 10'd300);
    tick();
    upd(3'd1, 11'd300, 10'd300);
    tick();
    upd_valid = 1'b0;
    vsync = 1'b1;
    tick();
    probe(11'd310, 10'd310);
    tick();
    check("overlap_base", pixel, BASE);
    hit = 4'b0010;
    tick();
    hit = '0;
    check("flash_pad1", {20'h0, flash_active}, FE ? 24'h2 : 24'h0);
    tick();
    check("pad0_wins", pixel, BASE);
    hit = 4'b0001;
    tick();
    hit = '0;
    check("flash_pad01", {20'h0, flash_active}, FE ? 24'h3 : 24'h0);
    tick();
    check("flash_color", pixel, FE ? FLASH : BASE);

    // pad 2 flash lasts exactly 8 commits
    hit = 4'b0100;
    tick();
    hit = '0;
    check("flash2_set", {23'h0, flash_active[2]}, {23'h0, FE});
    for (int k = 1; k <= 8; k++) begin
      rise('0);
      check($sformatf("flash2_rise%0d", k), {23'h0, flash_active[2]},
            (k < 8) ? {23'h0, FE} : 24'h0);
    end

    // hit coincident with the 4th commit reloads the count
    hit = 4'b0100;
    tick();
    hit = '0;
    for (int k = 1; k <= 3; k++) rise('0);
    rise(4'b0100);
    check("reload_on_c", {23'h0, flash_active[2]}, {23'h0, FE});
    for (int k = 1; k <= 7; k++) rise('0);
    check("reload_tail", {23'h0, flash_active[2]}, {23'h0, FE});
    rise('0);
    check("reload_end", {23'h0, flash_active[2]}, 24'h0);

    // asynchronous reset mid-flash restores defaults
    hit = 4'b0100;
    tick();
    hit = '0;
    rst_n = 1'b0;
    #1;
    check("midrst_flash", {20'h0, flash_active}, 24'h0);
    check("midrst_pixel", pixel, 24'h0);
    tick();
    rst_n = 1'b1;
    probe(11'd64, 10'd600);
    tick();
    check("midrst_pad0", pixel, BASE);
    probe(11'd330, 10'd610);
    tick();
    check("midrst_pad1", pixel, BASE);
    probe(11'd310, 10'd310);
    tick();
    check("midrst_old_pos", pixel, 24'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/pad_scheduler.md
# pad_scheduler

Frame-synchronous controller for the on-screen drum pads: it owns the position and flash state of NUM_PADS rectangular pads and arbitrates them into one 24-bit pixel stream. Position updates arrive through a valid/ready handshake into shadow registers and are committed atomically at the start of each frame, so a pad never tears mid-frame. Drum hits start a per-pad flash that lasts a fixed number of frames. The block sits between hit detection/game logic and the VGA pixel mixer.

## Interface
- NUM_PADS, 4: number of pads (1–8).
- WIDTH, 64: pad width in pixels.
- HEIGHT, 64: pad height in pixels.
- BASE_COLOR, 24'h00_80_FF: idle pad color.
- FLASH_COLOR, 24'hFF_FF_FF: color while flashing.
- FLASH_FRAMES, 8: flash duration in frames (1–255).
- clk  in  1  pixel clock.
- rst_n  in  1  asynchronous, active-low reset.
- hcount  in  11  current pixel column.
- vcount  in  10  current pixel row.
- vsync  in  1  active-high frame sync level.
- hit  in  NUM_PADS  one-cycle hit pulse per pad.
- upd_valid  in  1  position update request.
- upd_ready  out  1  update can be accepted this cycle.
- upd_id  in  3  target pad index.
- upd_x  in  11  new left edge.
- upd_y  in  10  new top edge.
- pixel  out  24  arbitrated pad color, 0 when no pad covers the pixel.
- flash_active  out  NUM_PADS  pad is currently flashing.
- frame_start  out  1  one-cycle pulse, the cycle after a commit.

## Operation
- Edge detect: vsync_q registers vsync. Commit cycle C = vsync & ~vsync_q.
- Handshake: upd_ready = ~C. An update is accepted when upd_valid & upd_ready. It writes shadow_x/shadow_y[upd_id]. upd_id >= NUM_PADS is accepted and discarded. Multiple updates to one pad before a commit: the last one wins.
- Commit: in cycle C, all active positions are loaded from the shadow registers. frame_start is asserted in cycle C+1.
- Reset defaults: shadow and active x = 64 + 256*i, y = 600 for pad i.
- Hit test per pad: hcount >= x && hcount < x+WIDTH && vcount >= y && vcount < y+HEIGHT.
  - Sums are computed at 12 and 11 bits; they never wrap. A pad past the right or bottom edge clips.
- Arbitration: fixed priority, lowest index wins. The color is FLASH_COLOR if that pad's flash_active is set, otherwise BASE_COLOR.
- Flash FSM per pad:
  - States: IDLE (cnt=0), FLASH (cnt>0).
  - A hit in any state loads cnt=FLASH_FRAMES and moves to FLASH.
  - In cycle C, FLASH decrements cnt. At cnt=0 it returns to IDLE.
  - A hit and C in the same cycle: the hit wins, cnt=FLASH_FRAMES with no decrement.
  - flash_active = (cnt != 0), registered.

## Timing
- pixel is registered with 1-cycle latency. pixel at cycle n+1 reflects hcount/vcount at cycle n, using the active positions and flash state of cycle n.
- Committed positions affect pixel starting with inputs sampled in cycle C+1.
- A hit pulse at cycle n sets flash_active at n+1.
- Flash duration: exactly FLASH_FRAMES commit edges after the hit, then it clears the cycle after the last decrementing C.
- Reset values, asynchronous on rst_n low:
  - pixel=0, flash_active=0, frame_start=0.
  - vsync_q=1, which prevents a spurious commit when vsync is high at reset release.
  - upd_ready=1 unless vsync rises.
  - Counters 0. Positions at their defaults.
- Reset mid-frame or mid-flash: all state returns to the defaults immediately. Pending shadow updates are lost.

## Configuration
- PAD_SCHED_FLASH_EN defined: flash counters and FSM are built as described above.
- PAD_SCHED_FLASH_EN undefined: no counters are built. flash_active is tied to 0, hit is ignored, and pixel uses only BASE_COLOR. Position, commit and arbitration behaviour are unchanged.

## Test plan
- Reset release with vsync=1, then hold vsync high for 10 cycles:
  - frame_start stays 0.
  - Pad 0 at hcount=64, vcount=600 gives pixel=24'h0080FF one cycle later.
- Update pad 1 to (500,100), then probe (510,110) before and after the next vsync rise:
  - Before the rise: pixel=0.
  - From C+1 onward, the probe gives 24'h0080FF.
  - frame_start pulses once.
- Drive upd_valid in the same cycle vsync rises:
  - upd_ready=0 and the update is not stored.
  - The same update held one more cycle is accepted.
- Move pads 0 and 1 to the same rectangle (300,300) and probe inside it:
  - Pad 0's color is shown.
  - After a hit on pad 1 only, pixel stays 24'h0080FF.
  - flash_active=4'b0010.
- Hit on pad 2, then 8 vsync rises:
  - flash_active[2]=1 through the 7th rise and clears after the 8th.
  - A hit coincident with the 4th rise reloads cnt to 8.
- Repeat the previous scenario with PAD_SCHED_FLASH_EN undefined: flash_active stays 0 and pixel never equals 24'hFFFFFF.
